// File: rtl/m14k_rf_xfer.sv
// rtl/m14k_rf_xfer.sv - register file save/restore sequencer
//
// Walks a contiguous GPR index range [first_reg..last_reg] through the RF.
// Save mode reads each register and streams it out on dout_*.
// Restore mode takes a din_* stream and writes each beat into the RF.
//
// Ports
//   gclk, greset                      clock, synchronous active-high reset
//   start, mode, first_reg, last_reg  transfer request, sampled only in IDLE
//   rf_req, rf_gnt                    RF port request / arbiter grant
//   rf_src, rf_read_data              RF read port (data is combinational)
//   rf_dest, rf_write_en,
//   rf_write_data                     RF write port
//   dout_valid, dout_ready, dout_data,
//   dout_idx, dout_last               save stream
//   din_valid, din_ready, din_data    restore stream
//   busy, done, xfer_count            status

module m14k_rf_xfer (
    input  logic        gclk,
    input  logic        greset,
    input  logic        start,
    input  logic        mode,
    input  logic [4:0]  first_reg,
    input  logic [4:0]  last_reg,
    output logic        rf_req,
    input  logic        rf_gnt,
    output logic [4:0]  rf_src,
    input  logic [31:0] rf_read_data,
    output logic [4:0]  rf_dest,
    output logic        rf_write_en,
    output logic [31:0] rf_write_data,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [31:0] dout_data,
    output logic [4:0]  dout_idx,
    output logic        dout_last,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [31:0] din_data,
    output logic        busy,
    output logic        done,
    output logic [5:0]  xfer_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_RESTORE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t     state;
    logic [4:0] cur_idx;
    logic [4:0] last_idx;

    logic at_last;
    logic out_hs;
    logic capture;
    logic din_hs;

    assign at_last = (cur_idx == last_idx);
    assign out_hs  = dout_valid && dout_ready;
    // The output register can take a new value when it is empty or being drained.
    assign capture = (state == ST_SAVE) && rf_gnt && (!dout_valid || dout_ready);

    // Restore is fully combinational so a granted beat is written in the cycle it arrives.
    assign din_ready     = (state == ST_RESTORE) && rf_gnt;
    assign din_hs        = din_valid && din_ready;
    // GPR 0 is hardwired zero: the beat is consumed but never written.
    assign rf_write_en   = din_hs && (cur_idx != 5'd0);
    assign rf_write_data = rf_write_en ? din_data : 32'd0;
    assign rf_dest       = cur_idx;
    assign rf_src        = cur_idx;

    always_ff @(posedge gclk) begin
        if (greset) begin
            state      <= ST_IDLE;
            cur_idx    <= 5'd0;
            last_idx   <= 5'd0;
            rf_req     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            xfer_count <= 6'd0;
            dout_valid <= 1'b0;
            dout_data  <= 32'd0;
            dout_idx   <= 5'd0;
            dout_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        xfer_count <= 6'd0;
                        if (first_reg <= last_reg) begin
                            cur_idx  <= first_reg;
                            last_idx <= last_reg;
                            rf_req   <= 1'b1;
                            busy     <= 1'b1;
                            state    <= mode ? ST_RESTORE : ST_SAVE;
                        end else begin
                            // Empty range: report completion without touching the RF.
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_SAVE: begin
                    if (out_hs) begin
                        xfer_count <= xfer_count + 6'd1;
                    end
                    if (capture) begin
                        dout_valid <= 1'b1;
                        dout_data  <= (cur_idx == 5'd0) ? 32'd0 : rf_read_data;
                        dout_idx   <= cur_idx;
                        dout_last  <= at_last;
                        if (at_last) begin
                            // Stop before incrementing so an index of 31 never wraps to 0.
                            rf_req <= 1'b0;
                            state  <= ST_FLUSH;
                        end else begin
                            cur_idx <= cur_idx + 5'd1;
                        end
                    end else if (out_hs) begin
                        dout_valid <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (out_hs) begin
                        dout_valid <= 1'b0;
                        xfer_count <= xfer_count + 6'd1;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_RESTORE: begin
                    if (din_hs) begin
                        xfer_count <= xfer_count + 6'd1;
                        if (at_last) begin
                            rf_req <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            cur_idx <= cur_idx + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m14k_rf_xfer.sv
// tb/tb_m14k_rf_xfer.sv - self-checking bench for m14k_rf_xfer
module tb_m14k_rf_xfer;

    logic        gclk = 1'b0;
    logic        greset;
    logic        start;
    logic        mode;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic        rf_req;
    logic        rf_gnt;
    logic [4:0]  rf_src;
    logic [31:0] rf_read_data;
    logic [4:0]  rf_dest;
    logic        rf_write_en;
    logic [31:0] rf_write_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] dout_data;
    logic [4:0]  dout_idx;
    logic        dout_last;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din_data;
    logic        busy;
    logic        done;
    logic [5:0]  xfer_count;

    int checks;
    int failures;

    logic        preload;
    logic [31:0] rf     [32];
    logic [31:0] rf_exp [32];

    always #5 gclk = ~gclk;

    m14k_rf_xfer dut (
        .gclk(gclk), .greset(greset), .start(start), .mode(mode),
        .first_reg(first_reg), .last_reg(last_reg),
        .rf_req(rf_req), .rf_gnt(rf_gnt), .rf_src(rf_src), .rf_read_data(rf_read_data),
        .rf_dest(rf_dest), .rf_write_en(rf_write_en), .rf_write_data(rf_write_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .dout_idx(dout_idx), .dout_last(dout_last),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .busy(busy), .done(done), .xfer_count(xfer_count)
    );

    // Register file model: combinational read, GPR 0 reads as zero.
    assign rf_read_data = (rf_src == 5'd0) ? 32'd0 : rf[rf_src];

    always @(posedge gclk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'd0 : 32'hA500_0000 + 32'(i);
        end else if (rf_write_en) begin
            rf[rf_dest] <= rf_write_data;
        end
    end

    task automatic do_start(input logic m, input logic [4:0] f, input logic [4:0] l);
        start = 1'b1; mode = m; first_reg = f; last_reg = l;
        @(negedge gclk);
        start = 1'b0; mode = 1'($urandom_range(0, 1));
        first_reg = 5'($urandom_range(0, 31)); last_reg = 5'($urandom_range(0, 31));
    endtask

    // Save transfer checked against the expected beat sequence first..last.
    task automatic run_save(input logic [4:0] f, input logic [4:0] l, input bit rnd,
                            input logic [31:0] rdy_pat, input logic [31:0] gnt_pat,
                            input bit inject, input bit timing);
        int n, got, hs_cyc, done_cyc;
        logic pv_stall, pv_last;
        logic [31:0] pv_data, exp_d;
        logic [4:0] pv_idx, exp_i;
        n = int'(l) - int'(f) + 1;
        got = 0; hs_cyc = -1; done_cyc = 0; pv_stall = 1'b0;
        pv_data = '0; pv_idx = '0; pv_last = 1'b0;
        do_start(1'b0, f, l);
        for (int cyc = 1; cyc <= 1000 && done_cyc == 0; cyc++) begin
            dout_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc < 32 ? rdy_pat[cyc] : 1'b1);
            rf_gnt     = rnd ? 1'($urandom_range(0, 1)) : (cyc < 32 ? gnt_pat[cyc] : 1'b1);
            if (inject && cyc == 3) begin
                start = 1'b1; mode = 1'b1; first_reg = 5'd0; last_reg = 5'd31;
            end else begin
                start = 1'b0;
            end
            #1;
            checks++;
            if (rf_write_en !== 1'b0 || din_ready !== 1'b0 || (!done && busy !== 1'b1)) begin
                failures++;
                $display("FAIL save_ctrl: we=%b din_ready=%b busy=%b, expected we=0 din_ready=0 busy=1",
                         rf_write_en, din_ready, busy);
            end
            if (pv_stall) begin
                checks++;
                if ({dout_valid, dout_data, dout_idx, dout_last} !== {1'b1, pv_data, pv_idx, pv_last}) begin
                    failures++;
                    $display("FAIL save_hold: v=%b d=%h i=%0d l=%b, expected v=1 d=%h i=%0d l=%b",
                             dout_valid, dout_data, dout_idx, dout_last, pv_data, pv_idx, pv_last);
                end
            end
            if (dout_valid && dout_ready) begin
                checks++;
                exp_i = 5'(int'(f) + got);
                exp_d = (exp_i == 5'd0) ? 32'd0 : rf_exp[exp_i];
                if (got >= n) begin
                    failures++;
                    $display("FAIL save_extra_beat: idx=%0d, expected only %0d beats", dout_idx, n);
                end else if (dout_idx !== exp_i || dout_data !== exp_d || dout_last !== (got == n - 1)) begin
                    failures++;
                    $display("FAIL save_beat: idx=%0d data=%h last=%b, expected idx=%0d data=%h last=%b",
                             dout_idx, dout_data, dout_last, exp_i, exp_d, (got == n - 1));
                end
                got++; hs_cyc = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                checks++;
                if (got !== n || hs_cyc !== cyc - 1 || busy !== 1'b0 || xfer_count !== 6'(n)) begin
                    failures++;
                    $display("FAIL save_done: beats=%0d last_hs=%0d busy=%b count=%0d, expected beats=%0d last_hs=%0d busy=0 count=%0d",
                             got, hs_cyc, busy, xfer_count, n, cyc - 1, n);
                end
            end
            pv_stall = dout_valid && !dout_ready;
            pv_data = dout_data; pv_idx = dout_idx; pv_last = dout_last;
            @(negedge gclk);
        end
        checks++;
        if (done_cyc == 0) begin
            failures++;
            $display("FAIL save_timeout: done=0 beats=%0d, expected done within budget", got);
        end
        if (timing) begin
            checks++;
            if (done_cyc !== n + 2) begin
                failures++;
                $display("FAIL save_latency: done_cycle=%0d, expected %0d", done_cyc, n + 2);
            end
        end
        start = 1'b0; dout_ready = 1'b1; rf_gnt = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0 || rf_req !== 1'b0 || xfer_count !== 6'(n)) begin
            failures++;
            $display("FAIL save_idle: done=%b busy=%b valid=%b req=%b count=%0d, expected 0 0 0 0 %0d",
                     done, busy, dout_valid, rf_req, xfer_count, n);
        end
        @(negedge gclk);
    endtask

    // Restore transfer; abort_after>0 asserts greset once that many beats are consumed.
    task automatic run_restore(input logic [4:0] f, input logic [4:0] l, input bit rnd, input int abort_after);
        int n, k;
        bit aborted;
        logic [31:0] d;
        logic [4:0] idx;
        n = int'(l) - int'(f) + 1;
        k = 0; aborted = 1'b0;
        d = rnd ? $urandom : 32'h11;
        do_start(1'b1, f, l);
        for (int cyc = 1; cyc <= 1000 && k < n && !aborted; cyc++) begin
            if (abort_after > 0 && k == abort_after) begin
                greset = 1'b1; din_valid = 1'b0; rf_gnt = 1'b1; dout_ready = 1'b1;
                @(negedge gclk);
                din_valid = 1'b1;
                #1;
                checks++;
                if ({rf_req, rf_write_en, dout_valid, din_ready, busy, done} !== 6'b0 || xfer_count !== 6'd0 ||
                    rf_src !== 5'd0 || rf_dest !== 5'd0 || rf_write_data !== 32'd0 ||
                    dout_data !== 32'd0 || dout_idx !== 5'd0 || dout_last !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_mid: req=%b we=%b v=%b rdy=%b busy=%b done=%b count=%0d src=%0d dest=%0d dd=%h di=%0d dl=%b, expected all 0",
                             rf_req, rf_write_en, dout_valid, din_ready, busy, done, xfer_count,
                             rf_src, rf_dest, dout_data, dout_idx, dout_last);
                end
                greset = 1'b0;
                aborted = 1'b1;
            end else begin
                din_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                rf_gnt     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                dout_ready = 1'($urandom_range(0, 1));
                din_data   = d;
                #1;
                checks++;
                if (din_ready !== rf_gnt || dout_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL restore_ctrl: din_ready=%b dout_valid=%b busy=%b done=%b, expected %b 0 1 0",
                             din_ready, dout_valid, busy, done, rf_gnt);
                end
                checks++;
                if (din_valid && din_ready) begin
                    idx = 5'(int'(f) + k);
                    if (rf_write_en !== (idx != 5'd0) ||
                        (idx != 5'd0 && (rf_dest !== idx || rf_write_data !== d))) begin
                        failures++;
                        $display("FAIL restore_write: we=%b dest=%0d data=%h, expected we=%b dest=%0d data=%h",
                                 rf_write_en, rf_dest, rf_write_data, (idx != 5'd0), idx, d);
                    end
                    if (idx != 5'd0) rf_exp[idx] = d;
                    k++;
                    d = rnd ? $urandom : 32'h11 * 32'(k + 1);
                end else if (rf_write_en !== 1'b0) begin
                    failures++;
                    $display("FAIL restore_idle_write: we=%b, expected 0", rf_write_en);
                end
                @(negedge gclk);
            end
        end
        if (!aborted) begin
            din_valid = 1'b0; rf_gnt = 1'b1;
            #1;
            checks++;
            if (k !== n || done !== 1'b1 || busy !== 1'b0 || xfer_count !== 6'(n) || rf_req !== 1'b0 || din_ready !== 1'b0) begin
                failures++;
                $display("FAIL restore_done: beats=%0d done=%b busy=%b count=%0d req=%b rdy=%b, expected %0d 1 0 %0d 0 0",
                         k, done, busy, xfer_count, rf_req, din_ready, n, n);
            end
            @(negedge gclk);
            #1;
            checks++;
            if (done !== 1'b0 || xfer_count !== 6'(n)) begin
                failures++;
                $display("FAIL restore_pulse: done=%b count=%0d, expected 0 %0d", done, xfer_count, n);
            end
            @(negedge gclk);
        end
    endtask

    task automatic test_reset;
        greset = 1'b1; preload = 1'b1;
        start = 1'b0; mode = 1'b0; first_reg = '0; last_reg = '0;
        rf_gnt = 1'b1; dout_ready = 1'b1; din_valid = 1'b1; din_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 32; i++) rf_exp[i] = (i == 0) ? 32'd0 : 32'hA500_0000 + 32'(i);
        repeat (3) @(negedge gclk);
        #1;
        checks++;
        if ({rf_req, rf_write_en, dout_valid, din_ready, busy, done} !== 6'b0 || xfer_count !== 6'd0 ||
            rf_src !== 5'd0 || rf_dest !== 5'd0 || dout_data !== 32'd0 || dout_idx !== 5'd0 || dout_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: req=%b we=%b v=%b rdy=%b busy=%b done=%b count=%0d, expected all 0",
                     rf_req, rf_write_en, dout_valid, din_ready, busy, done, xfer_count);
        end
        greset = 1'b0; preload = 1'b0; din_valid = 1'b0;
        @(negedge gclk);
    endtask

    task automatic test_empty_range;
        do_start(1'b0, 5'd9, 5'd8);
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rf_req !== 1'b0 || dout_valid !== 1'b0 || xfer_count !== 6'd0) begin
            failures++;
            $display("FAIL empty_range: done=%b busy=%b req=%b valid=%b count=%0d, expected 1 0 0 0 0",
                     done, busy, rf_req, dout_valid, xfer_count);
        end
        @(negedge gclk);
        #1;
        checks++;
        if (done !== 1'b0 || rf_req !== 1'b0) begin
            failures++;
            $display("FAIL empty_pulse: done=%b req=%b, expected 0 0", done, rf_req);
        end
        @(negedge gclk);
    endtask

    task automatic test_random;
        logic [4:0] f, l;
        for (int t = 0; t < 8; t++) begin
            f = 5'($urandom_range(0, 31));
            l = 5'($urandom_range(int'(f), 31));
            if ($urandom_range(0, 1) == 1) run_restore(f, l, 1'b1, 0);
            else run_save(f, l, 1'b1, '1, '1, 1'b0, 1'b0);
        end
        run_restore(5'd0, 5'd31, 1'b1, 0);
        run_save(5'd0, 5'd31, 1'b1, '1, '1, 1'b0, 1'b0);
    endtask

    task automatic test_rf_contents;
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (rf[i] !== rf_exp[i]) begin
                failures++;
                $display("FAIL rf_contents: rf%0d=%h, expected %h", i, rf[i], rf_exp[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        run_save(5'd1, 5'd31, 1'b0, '1, '1, 1'b0, 1'b1);
        run_save(5'd4, 5'd6, 1'b0, 32'hFFFF_FFF3, 32'hFFFF_FFE7, 1'b0, 1'b0);
        run_restore(5'd0, 5'd3, 1'b0, 0);
        test_empty_range;
        run_restore(5'd10, 5'd14, 1'b0, 2);
        run_save(5'd10, 5'd13, 1'b0, '1, '1, 1'b0, 1'b1);
        run_save(5'd20, 5'd23, 1'b1, '1, '1, 1'b1, 1'b0);
        test_random;
        test_rf_contents;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
